// File: rtl/riscv_pkg.sv
// Shared RISC-V core definitions: datapath width and the branch-queue entry layout.
package riscv_pkg;

    localparam int XLEN = 32;

    // One in-flight branch as recorded at fetch time.
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic            hit;
        logic            taken;
        logic [XLEN-1:0] tgt;
    } pq_entry_t;

endpackage

// File: rtl/pq_fifo.sv
// Synchronous program-order FIFO of pq_entry_t with a single-cycle clear.
// The head entry is presented combinationally so the consumer can compare before popping.
module pq_fifo
    import riscv_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic      clk,
    input  logic      reset,
    input  logic      clear,
    input  logic      push,
    input  pq_entry_t push_data,
    input  logic      pop,
    output pq_entry_t head,
    output logic      full,
    output logic      empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    pq_entry_t        mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             push_en;
    logic             pop_en;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign push_en = push & ~full;
    assign pop_en  = pop & ~empty;
    assign head    = mem[rd_ptr];

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_en) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop_en)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(push_en) - CNT_W'(pop_en);
        end
    end

    // NOTE: storage is deliberately not reset; validity is tracked by count,
    // and leaving the array reset-free lets it map onto plain RAM/flops.
    always_ff @(posedge clk) begin
        if (push_en) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/br_resolve.sv
// Branch resolution: queues fetched branches, matches them against execute
// results, drives predictor updates and a one-cycle mispredict redirect.
module br_resolve
    import riscv_pkg::*;
#(
    parameter int PQ_DEPTH = 4
) (
    input  logic            clk,
    input  logic            reset,

    input  logic            push_v_i,
    input  logic [XLEN-1:0] push_pc_i,
    input  logic            push_hit_i,
    input  logic            push_taken_i,
    input  logic [XLEN-1:0] push_tgt_i,
    output logic            push_ready_o,

    input  logic            exe_v_i,
    input  logic [XLEN-1:0] exe_pc_i,
    input  logic            exe_taken_i,
    input  logic [XLEN-1:0] exe_tgt_i,

    output logic            pred_en_o,
    output logic [XLEN-1:0] bu_pc_branch_o,
    output logic [XLEN-1:0] bu_pc_target_o,
    output logic            bu_pred_success_o,
    output logic            bu_pred_failed_o,
    output logic            flush_v_o,
    output logic [XLEN-1:0] flush_pc_o,
    output logic            err_o
);

    pq_entry_t head;
    pq_entry_t push_entry;
    logic      full;
    logic      empty;
    logic      push_fire;
    logic      pop_fire;
    logic      resolve_ok;
    logic      resolve_err;
    logic      mispredict;
    logic      head_taken;

    assign push_entry = '{pc: push_pc_i, hit: push_hit_i, taken: push_taken_i, tgt: push_tgt_i};
    assign push_ready_o = ~full;

    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        resolve_ok  = 1'b0;
        resolve_err = 1'b0;
        mispredict  = 1'b0;
        head_taken  = head.hit & head.taken;
        if (exe_v_i) begin
            if (empty || (exe_pc_i != head.pc)) begin
                resolve_err = 1'b1;
            end else begin
                resolve_ok = 1'b1;
                mispredict = (head_taken != exe_taken_i) |
                             (exe_taken_i & (head.tgt != exe_tgt_i));
            end
        end
    end

    // Pushes are squashed both in the mispredict cycle and in the redirect cycle.
    assign push_fire = push_v_i & ~full & ~flush_v_o & ~mispredict;
    assign pop_fire  = exe_v_i & ~empty;

    pq_fifo #(
        .DEPTH(PQ_DEPTH)
    ) u_pq_fifo (
        .clk      (clk),
        .reset    (reset),
        .clear    (mispredict),
        .push     (push_fire),
        .push_data(push_entry),
        .pop      (pop_fire),
        .head     (head),
        .full     (full),
        .empty    (empty)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            pred_en_o         <= 1'b0;
            bu_pred_success_o <= 1'b0;
            bu_pred_failed_o  <= 1'b0;
            flush_v_o         <= 1'b0;
            err_o             <= 1'b0;
            bu_pc_branch_o    <= '0;
            bu_pc_target_o    <= '0;
            flush_pc_o        <= '0;
        end else begin
            pred_en_o         <= resolve_ok & (head.hit | exe_taken_i);
            bu_pred_success_o <= resolve_ok & head.hit & exe_taken_i;
            bu_pred_failed_o  <= resolve_ok & head.hit & ~exe_taken_i;
            flush_v_o         <= mispredict;
            err_o             <= resolve_err;
            if (resolve_ok) begin
                bu_pc_branch_o <= exe_pc_i;
                bu_pc_target_o <= exe_tgt_i;
            end
            if (mispredict) begin
                flush_pc_o <= exe_taken_i ? exe_tgt_i : exe_pc_i + XLEN'(4);
            end
        end
    end

endmodule

// File: tb/tb_br_resolve.sv
// Directed self-checking bench for br_resolve with hand-computed expectations.
module tb_br_resolve;
    import riscv_pkg::*;

    localparam int PQ_DEPTH = 4;

    logic            clk = 1'b0;
    logic            reset;
    logic            push_v_i;
    logic [XLEN-1:0] push_pc_i;
    logic            push_hit_i;
    logic            push_taken_i;
    logic [XLEN-1:0] push_tgt_i;
    logic            push_ready_o;
    logic            exe_v_i;
    logic [XLEN-1:0] exe_pc_i;
    logic            exe_taken_i;
    logic [XLEN-1:0] exe_tgt_i;
    logic            pred_en_o;
    logic [XLEN-1:0] bu_pc_branch_o;
    logic [XLEN-1:0] bu_pc_target_o;
    logic            bu_pred_success_o;
    logic            bu_pred_failed_o;
    logic            flush_v_o;
    logic [XLEN-1:0] flush_pc_o;
    logic            err_o;

    int checks = 0;
    int errors = 0;

    br_resolve #(.PQ_DEPTH(PQ_DEPTH)) dut (
        .clk              (clk),
        .reset            (reset),
        .push_v_i         (push_v_i),
        .push_pc_i        (push_pc_i),
        .push_hit_i       (push_hit_i),
        .push_taken_i     (push_taken_i),
        .push_tgt_i       (push_tgt_i),
        .push_ready_o     (push_ready_o),
        .exe_v_i          (exe_v_i),
        .exe_pc_i         (exe_pc_i),
        .exe_taken_i      (exe_taken_i),
        .exe_tgt_i        (exe_tgt_i),
        .pred_en_o        (pred_en_o),
        .bu_pc_branch_o   (bu_pc_branch_o),
        .bu_pc_target_o   (bu_pc_target_o),
        .bu_pred_success_o(bu_pred_success_o),
        .bu_pred_failed_o (bu_pred_failed_o),
        .flush_v_o        (flush_v_o),
        .flush_pc_o       (flush_pc_o),
        .err_o            (err_o)
    );

    always #5 clk = ~clk;

    // {pred_en, success, failed, flush_v, err}
    function automatic logic [4:0] strobes();
        return {pred_en_o, bu_pred_success_o, bu_pred_failed_o, flush_v_o, err_o};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        push_v_i     = 1'b0;
        push_pc_i    = '0;
        push_hit_i   = 1'b0;
        push_taken_i = 1'b0;
        push_tgt_i   = '0;
        exe_v_i      = 1'b0;
        exe_pc_i     = '0;
        exe_taken_i  = 1'b0;
        exe_tgt_i    = '0;
    endtask

    task automatic set_push(input logic [XLEN-1:0] pc, input logic hit, input logic taken,
                            input logic [XLEN-1:0] tgt);
        push_v_i     = 1'b1;
        push_pc_i    = pc;
        push_hit_i   = hit;
        push_taken_i = taken;
        push_tgt_i   = tgt;
    endtask

    task automatic set_resolve(input logic [XLEN-1:0] pc, input logic taken,
                               input logic [XLEN-1:0] tgt);
        exe_v_i     = 1'b1;
        exe_pc_i    = pc;
        exe_taken_i = taken;
        exe_tgt_i   = tgt;
    endtask

    task automatic do_push(input logic [XLEN-1:0] pc, input logic hit, input logic taken,
                           input logic [XLEN-1:0] tgt);
        set_push(pc, hit, taken, tgt);
        tick();
        clear_inputs();
    endtask

    task automatic do_resolve(input logic [XLEN-1:0] pc, input logic taken,
                              input logic [XLEN-1:0] tgt);
        set_resolve(pc, taken, tgt);
        tick();
        clear_inputs();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        set_push(32'h40, 1'b1, 1'b1, 32'h80);
        set_resolve(32'h40, 1'b1, 32'h80);
        tick();
        tick();
        checks++; if (push_ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", push_ready_o); end
        checks++; if (strobes() !== 5'b00000) begin errors++; $display("FAIL reset_strobes: got %b expected 00000", strobes()); end
        checks++; if (bu_pc_branch_o !== '0) begin errors++; $display("FAIL reset_bu_pc_branch: got %h expected 0", bu_pc_branch_o); end
        checks++; if (bu_pc_target_o !== '0) begin errors++; $display("FAIL reset_bu_pc_target: got %h expected 0", bu_pc_target_o); end
        checks++; if (flush_pc_o !== '0) begin errors++; $display("FAIL reset_flush_pc: got %h expected 0", flush_pc_o); end
        reset = 1'b0;
        clear_inputs();
        tick();
        checks++; if (strobes() !== 5'b00000) begin errors++; $display("FAIL reset_idle_strobes: got %b expected 00000", strobes()); end
        do_resolve(32'h40, 1'b1, 32'h80);
        checks++; if (strobes() !== 5'b00001) begin errors++; $display("FAIL reset_push_ignored: got %b expected 00001", strobes()); end
    endtask

    task automatic test_hit_taken();
        do_push(32'h100, 1'b1, 1'b1, 32'h200);
        do_resolve(32'h100, 1'b1, 32'h200);
        checks++; if (strobes() !== 5'b11000) begin errors++; $display("FAIL hit_taken_strobes: got %b expected 11000", strobes()); end
        checks++; if (bu_pc_branch_o !== 32'h100) begin errors++; $display("FAIL hit_taken_pc: got %h expected 100", bu_pc_branch_o); end
        checks++; if (bu_pc_target_o !== 32'h200) begin errors++; $display("FAIL hit_taken_tgt: got %h expected 200", bu_pc_target_o); end
        do_resolve(32'h100, 1'b1, 32'h200);
        checks++; if (strobes() !== 5'b00001) begin errors++; $display("FAIL hit_taken_empty: got %b expected 00001", strobes()); end
        tick();
        checks++; if (strobes() !== 5'b00000) begin errors++; $display("FAIL hit_taken_err_pulse: got %b expected 00000", strobes()); end
    endtask

    task automatic test_miss_taken();
        do_push(32'h100, 1'b0, 1'b0, 32'h0);
        do_resolve(32'h100, 1'b1, 32'h300);
        checks++; if (strobes() !== 5'b10010) begin errors++; $display("FAIL miss_taken_strobes: got %b expected 10010", strobes()); end
        checks++; if (flush_pc_o !== 32'h300) begin errors++; $display("FAIL miss_taken_flush_pc: got %h expected 300", flush_pc_o); end
        tick();
        checks++; if (strobes() !== 5'b00000) begin errors++; $display("FAIL miss_taken_one_cycle: got %b expected 00000", strobes()); end
        do_resolve(32'h100, 1'b1, 32'h300);
        checks++; if (strobes() !== 5'b00001) begin errors++; $display("FAIL miss_taken_empty: got %b expected 00001", strobes()); end
    endtask

    task automatic test_mispredict_flush();
        do_push(32'h100, 1'b1, 1'b1, 32'h200);
        do_push(32'h104, 1'b0, 1'b0, 32'h0);
        // Push offered in the mispredict cycle itself
        set_push(32'h600, 1'b0, 1'b0, 32'h0);
        set_resolve(32'h100, 1'b0, 32'h0);
        tick();
        clear_inputs();
        checks++; if (strobes() !== 5'b10110) begin errors++; $display("FAIL flush_strobes: got %b expected 10110", strobes()); end
        checks++; if (flush_pc_o !== 32'h104) begin errors++; $display("FAIL flush_pc: got %h expected 104", flush_pc_o); end
        do_push(32'h500, 1'b0, 1'b0, 32'h0);
        checks++; if (strobes() !== 5'b00000) begin errors++; $display("FAIL flush_one_cycle: got %b expected 00000", strobes()); end
        // A fresh entry must now be the head; any survivor would raise err_o
        do_push(32'h700, 1'b0, 1'b0, 32'h0);
        do_resolve(32'h700, 1'b0, 32'h0);
        checks++; if (strobes() !== 5'b00000) begin errors++; $display("FAIL flush_fifo_cleared: got %b expected 00000", strobes()); end
        do_resolve(32'h700, 1'b0, 32'h0);
        checks++; if (strobes() !== 5'b00001) begin errors++; $display("FAIL flush_after_empty: got %b expected 00001", strobes()); end
    endtask

    task automatic test_full_wrap();
        logic [XLEN-1:0] exp_pc  [4];
        logic [XLEN-1:0] exp_tgt [4];
        for (int i = 0; i < PQ_DEPTH; i++) begin
            do_push(32'h1000 + 32'(4 * i), 1'b1, 1'b1, 32'h2000 + 32'(16 * i));
        end
        checks++; if (push_ready_o !== 1'b0) begin errors++; $display("FAIL full_ready: got %b expected 0", push_ready_o); end
        set_push(32'h1010, 1'b1, 1'b1, 32'h2040);
        set_resolve(32'h1000, 1'b1, 32'h2000);
        tick();
        clear_inputs();
        checks++; if (strobes() !== 5'b11000) begin errors++; $display("FAIL full_pop_strobes: got %b expected 11000", strobes()); end
        checks++; if (bu_pc_branch_o !== 32'h1000) begin errors++; $display("FAIL full_pop_pc: got %h expected 1000", bu_pc_branch_o); end
        checks++; if (push_ready_o !== 1'b1) begin errors++; $display("FAIL full_after_pop_ready: got %b expected 1", push_ready_o); end
        do_push(32'h1014, 1'b1, 1'b1, 32'h2050);
        checks++; if (push_ready_o !== 1'b0) begin errors++; $display("FAIL full_refill_ready: got %b expected 0", push_ready_o); end
        exp_pc  = '{32'h1004, 32'h1008, 32'h100C, 32'h1014};
        exp_tgt = '{32'h2010, 32'h2020, 32'h2030, 32'h2050};
        for (int i = 0; i < 4; i++) begin
            do_resolve(exp_pc[i], 1'b1, exp_tgt[i]);
            checks++; if (strobes() !== 5'b11000) begin errors++; $display("FAIL wrap_strobes[%0d]: got %b expected 11000", i, strobes()); end
            checks++; if (bu_pc_target_o !== exp_tgt[i]) begin errors++; $display("FAIL wrap_tgt[%0d]: got %h expected %h", i, bu_pc_target_o, exp_tgt[i]); end
        end
        checks++; if (push_ready_o !== 1'b1) begin errors++; $display("FAIL wrap_drained_ready: got %b expected 1", push_ready_o); end
        do_resolve(32'h1010, 1'b1, 32'h2040);
        checks++; if (strobes() !== 5'b00001) begin errors++; $display("FAIL wrap_empty: got %b expected 00001", strobes()); end
    endtask

    task automatic test_errors();
        tick();
        do_resolve(32'h100, 1'b1, 32'h200);
        checks++; if (strobes() !== 5'b00001) begin errors++; $display("FAIL err_empty: got %b expected 00001", strobes()); end
        tick();
        checks++; if (strobes() !== 5'b00000) begin errors++; $display("FAIL err_pulse: got %b expected 00000", strobes()); end
        do_push(32'h100, 1'b1, 1'b1, 32'h200);
        do_push(32'h10C, 1'b0, 1'b0, 32'h0);
        do_resolve(32'h108, 1'b1, 32'h200);
        checks++; if (strobes() !== 5'b00001) begin errors++; $display("FAIL err_pc_mismatch: got %b expected 00001", strobes()); end
        do_resolve(32'h10C, 1'b0, 32'h0);
        checks++; if (strobes() !== 5'b00000) begin errors++; $display("FAIL err_head_popped: got %b expected 00000", strobes()); end
        do_resolve(32'h10C, 1'b0, 32'h0);
        checks++; if (strobes() !== 5'b00001) begin errors++; $display("FAIL err_drained: got %b expected 00001", strobes()); end
    endtask

    task automatic test_reset_mid();
        do_push(32'h100, 1'b1, 1'b1, 32'h200);
        do_push(32'h104, 1'b1, 1'b1, 32'h208);
        do_push(32'h108, 1'b1, 1'b0, 32'h0);
        reset = 1'b1;
        set_push(32'h10C, 1'b1, 1'b1, 32'h210);
        set_resolve(32'h100, 1'b0, 32'h0);
        tick();
        checks++; if (push_ready_o !== 1'b1) begin errors++; $display("FAIL mid_reset_ready: got %b expected 1", push_ready_o); end
        checks++; if (strobes() !== 5'b00000) begin errors++; $display("FAIL mid_reset_strobes: got %b expected 00000", strobes()); end
        checks++; if (bu_pc_branch_o !== '0) begin errors++; $display("FAIL mid_reset_bu_pc: got %h expected 0", bu_pc_branch_o); end
        reset = 1'b0;
        clear_inputs();
        tick();
        do_resolve(32'h100, 1'b1, 32'h200);
        checks++; if (strobes() !== 5'b00001) begin errors++; $display("FAIL mid_reset_discard: got %b expected 00001", strobes()); end
    endtask

    initial begin
        reset = 1'b1;
        clear_inputs();
        test_reset();
        test_hit_taken();
        test_miss_taken();
        test_mispredict_flush();
        test_full_wrap();
        test_errors();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
